// File: rtl/agg_bank_writer.sv
// agg_bank_writer: ping-pong writer that packs incoming elements into two
// three-element banks. A bank becomes HELD once its third element lands and
// stays HELD (stalling the producer if it is the bank being filled) until the
// reader releases it. Bank contents are registered and survive a release.
module agg_bank_writer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             release_0,
    input  logic             release_1,
    output logic [WIDTH-1:0] bank0_0,
    output logic [WIDTH-1:0] bank0_1,
    output logic [WIDTH-1:0] bank0_2,
    output logic [WIDTH-1:0] bank1_0,
    output logic [WIDTH-1:0] bank1_1,
    output logic [WIDTH-1:0] bank1_2,
    output logic [1:0]       full,
    output logic             wr_bank,
    output logic [1:0]       wr_idx
);

    // Per-bank occupancy: FILLING accepts writes, HELD waits for the reader.
    typedef enum logic {
        FILLING = 1'b0,
        HELD    = 1'b1
    } bank_state_t;

    bank_state_t      state0_q, state0_d;
    bank_state_t      state1_q, state1_d;
    logic             wr_bank_q, wr_bank_d;
    logic [1:0]       wr_idx_q, wr_idx_d;

    logic             accept;
    logic             last_slot;

    logic [WIDTH-1:0] b0_q [3];
    logic [WIDTH-1:0] b1_q [3];

    // in_ready depends only on registered state so a release never
    // propagates combinationally to the producer.
    assign in_ready  = wr_bank_q ? (state1_q == FILLING) : (state0_q == FILLING);
    assign accept    = in_valid && in_ready;
    // Index 2 (or anything above, which is unreachable) closes the bank.
    assign last_slot = (wr_idx_q >= 2'd2);

    // Next-state logic: releases and the closing accept may hit different
    // banks in the same cycle and both take effect.
    always_comb begin
        state0_d  = state0_q;
        state1_d  = state1_q;
        wr_idx_d  = wr_idx_q;
        wr_bank_d = wr_bank_q;

        if (release_0 && (state0_q == HELD)) begin
            state0_d = FILLING;
        end
        if (release_1 && (state1_q == HELD)) begin
            state1_d = FILLING;
        end

        if (accept) begin
            if (last_slot) begin
                wr_idx_d  = 2'd0;
                wr_bank_d = ~wr_bank_q;
                if (wr_bank_q) begin
                    state1_d = HELD;
                end else begin
                    state0_d = HELD;
                end
            end else begin
                wr_idx_d = wr_idx_q + 2'd1;
            end
        end
    end

    // Control state register; reset discards any partial fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            state0_q  <= FILLING;
            state1_q  <= FILLING;
            wr_idx_q  <= 2'd0;
            wr_bank_q <= 1'b0;
        end else begin
            state0_q  <= state0_d;
            state1_q  <= state1_d;
            wr_idx_q  <= wr_idx_d;
            wr_bank_q <= wr_bank_d;
        end
    end

    // Bank storage: only an accept writes, so HELD banks and released banks
    // keep their contents until the slot is refilled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                b0_q[i] <= '0;
                b1_q[i] <= '0;
            end
        end else if (accept) begin
            if (!wr_bank_q) begin
                case (wr_idx_q)
                    2'd0:    b0_q[0] <= in_data;
                    2'd1:    b0_q[1] <= in_data;
                    default: b0_q[2] <= in_data;
                endcase
            end else begin
                case (wr_idx_q)
                    2'd0:    b1_q[0] <= in_data;
                    2'd1:    b1_q[1] <= in_data;
                    default: b1_q[2] <= in_data;
                endcase
            end
        end
    end

    assign bank0_0 = b0_q[0];
    assign bank0_1 = b0_q[1];
    assign bank0_2 = b0_q[2];
    assign bank1_0 = b1_q[0];
    assign bank1_1 = b1_q[1];
    assign bank1_2 = b1_q[2];
    assign full    = {state1_q == HELD, state0_q == HELD};
    assign wr_bank = wr_bank_q;
    assign wr_idx  = wr_idx_q;

endmodule

// File: doc/agg_bank_writer.md
AGG_BANK_WRITER -- requirements
Module: agg_bank_writer

Interface
REQ-001 SHALL have one parameter: WIDTH, default 3, bit width of every element.
REQ-002 SHALL have one clock and one reset: the clock is `clk` and the reset is `rst`, synchronous and active-high.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1  producer offers in_data this cycle.
REQ-006 SHALL have port in_data  input  WIDTH  element to be written.
REQ-007 SHALL have port in_ready  output  1  writer can accept in_data this cycle.
REQ-008 SHALL have port release_0  input  1  reader frees bank 0.
REQ-009 SHALL have port release_1  input  1  reader frees bank 1.
REQ-010 SHALL have ports bank0_0, bank0_1, bank0_2  output  WIDTH each  registered contents of bank 0, elements 0..2.
REQ-011 SHALL have ports bank1_0, bank1_1, bank1_2  output  WIDTH each  registered contents of bank 1, elements 0..2.
REQ-012 SHALL have port full  output  2  full[b]=1 means bank b holds 3 valid elements.
REQ-013 SHALL have port wr_bank  output  1  bank currently being filled (state).
REQ-014 SHALL have port wr_idx  output  2  next element index within wr_bank, range 0..2.

Function
REQ-015 SHALL drive in_ready = !full[wr_bank], combinationally from registers only, with no dependency on in_valid.
REQ-016 SHALL treat a cycle with in_valid && in_ready as an accept; no other cycle changes bank contents.
REQ-017 SHALL, on an accept, write in_data into element wr_idx of bank wr_bank at the next clk edge, with a latency of 1 cycle to the bank output.
REQ-018 SHALL, on an accept with wr_idx<2, increment wr_idx by 1 and keep wr_bank unchanged.
REQ-019 SHALL, on an accept with wr_idx==2, set full[wr_bank]=1, clear wr_idx to 0 and toggle wr_bank.
REQ-020 SHALL never let wr_idx reach 3; 2 wraps to 0 only via REQ-019.
REQ-021 SHALL treat the state machine as two states per bank, FILLING (full=0) and HELD (full=1): FILLING->HELD on the third accept, HELD->FILLING on release.
REQ-022 SHALL, on release_b=1 while full[b]=1, clear full[b] at the next edge; bank b contents stay unchanged until overwritten.
REQ-023 SHALL ignore release_b when full[b]=0, with no state change.
REQ-024 SHALL, when wr_bank's bank is full (both banks full), hold in_ready=0 and leave wr_idx/wr_bank unchanged; a stalled in_data is not lost, because the producer holds it.
REQ-025 SHALL, when both banks are full and release of wr_bank's bank is asserted, raise in_ready only in the following cycle and not combinationally from release.
REQ-026 SHALL, on a simultaneous third accept into bank b and release of bank !b, perform both updates in the same edge: full[b]=1 and full[!b]=0.
REQ-027 SHALL, on simultaneous release_0 and release_1 with both full, clear both flags.
REQ-028 SHALL keep HELD bank outputs stable while the other bank is filled.

Reset
REQ-029 SHALL, while rst=1 at a clk edge, set wr_bank=0, wr_idx=0, full=2'b00 and all six bank outputs to 0, regardless of in_valid and release.
REQ-030 SHALL, on reset asserted mid-fill (wr_idx≠0), discard the partial fill, and the first accept after reset SHALL write bank0_0.
REQ-031 SHALL make in_ready=1 in the first cycle after reset.

Verification
REQ-032 SHALL cover: reset, then accept 5,6,7 on consecutive cycles -> bank0_0/1/2=5/6/7, full=01, wr_bank=1, wr_idx=0, in_ready=1.
REQ-033 SHALL cover: accept six elements 1..6 with no release -> bank1_0/1/2=4/5/6, full=11, in_ready=0; a seventh in_valid is not accepted and wr_idx stays 0.
REQ-034 SHALL cover: from full=11, wr_bank=0, pulse release_0 -> full=10 next cycle, in_ready=1 one cycle after release, and bank0 outputs retain their old values until written.
REQ-035 SHALL cover: third accept into bank 1 in the same cycle as release_0 with full=01 -> full=10, wr_bank=0.
REQ-036 SHALL cover: release_1 pulsed while full=00 -> no change to any output.
REQ-037 SHALL cover: accept 3,2 (wr_idx=2), then rst for one cycle, then accept 7 -> bank0_0=7, bank0_1=0, wr_idx=1, full=00.
